// File: rtl/glb_2_lb_dma.sv
// Global-buffer to local-buffer 3-D tile mover: strided reads out of the global
// buffer, contiguous writes into a local buffer, with optional zero-fill mode.
module glb_2_lb_dma #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned GLB_AW   = 15,
    parameter int unsigned LB_AW    = 10,
    parameter int unsigned DIM_W    = 6,
    parameter int unsigned STRIDE_W = 8,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic [GLB_AW-1:0]   cfg_glb_base,
    input  logic [LB_AW-1:0]    cfg_lb_base,
    input  logic [STRIDE_W-1:0] cfg_row_stride,
    input  logic [GLB_AW-1:0]   cfg_ch_stride,
    input  logic [DIM_W-1:0]    cfg_length,
    input  logic [DIM_W-1:0]    cfg_height,
    input  logic [DIM_W-1:0]    cfg_depth,
    input  logic                cfg_zero_fill,
    output logic                rd_en,
    output logic [GLB_AW-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                wr_en,
    output logic [LB_AW-1:0]    wr_addr,
    output logic [DATA_W-1:0]   wr_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e              state_q;
    logic [STRIDE_W-1:0] row_stride_q;
    logic [GLB_AW-1:0]   ch_stride_q;
    logic [DIM_W-1:0]    len_q, hgt_q, dep_q;
    logic                zf_q;
    logic [DIM_W-1:0]    x_q, r_q, c_q;
    logic [DIM_W-1:0]    x_d, r_d, c_d;
    logic [GLB_AW-1:0]   addr_q, row_q, ch_q;
    logic [GLB_AW-1:0]   addr_d, row_d, ch_d;
    logic                acc_v_q;
    logic                rd_en_q;
    logic [GLB_AW-1:0]   rd_addr_q;
    logic [RD_LAT-1:0]   vpipe_q;
    logic [LB_AW-1:0]    wr_ptr_q;
    logic [LB_AW-1:0]    wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                busy_q, done_q;

    logic                x_end, r_end, c_end, last_acc;
    logic [RD_LAT:0]     vchain;
    logic                wr_fire, pipe_pending;

    assign x_end    = (x_q == len_q - 1'b1);
    assign r_end    = (r_q == hgt_q - 1'b1);
    assign c_end    = (c_q == dep_q - 1'b1);
    assign last_acc = x_end & r_end & c_end;

    // vchain[0] is the access currently on the read port; vchain[RD_LAT] is wr_en.
    // Read data is captured on the edge that moves an access into the last stage.
    assign vchain       = {vpipe_q, acc_v_q};
    assign wr_fire      = vchain[RD_LAT-1];
    assign pipe_pending = |vchain[RD_LAT-1:0];

    // Row and channel start addresses are kept incrementally, so no multipliers.
    always_comb begin
        x_d    = x_q;
        r_d    = r_q;
        c_d    = c_q;
        addr_d = addr_q;
        row_d  = row_q;
        ch_d   = ch_q;
        if (!x_end) begin
            x_d    = x_q + 1'b1;
            addr_d = addr_q + 1'b1;
        end else if (!r_end) begin
            x_d    = '0;
            r_d    = r_q + 1'b1;
            row_d  = row_q + GLB_AW'(row_stride_q);
            addr_d = row_d;
        end else begin
            x_d    = '0;
            r_d    = '0;
            c_d    = c_q + 1'b1;
            ch_d   = ch_q + ch_stride_q;
            row_d  = ch_d;
            addr_d = ch_d;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_stride_q <= '0;
            ch_stride_q  <= '0;
            len_q        <= '0;
            hgt_q        <= '0;
            dep_q        <= '0;
            zf_q         <= 1'b0;
            x_q          <= '0;
            r_q          <= '0;
            c_q          <= '0;
            addr_q       <= '0;
            row_q        <= '0;
            ch_q         <= '0;
            acc_v_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            vpipe_q      <= '0;
            wr_ptr_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            vpipe_q   <= vchain[RD_LAT-1:0];
            wr_data_q <= '0;
            if (wr_fire) begin
                wr_addr_q <= wr_ptr_q;
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                if (!zf_q) wr_data_q <= rd_data;
            end
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    acc_v_q <= 1'b0;
                    rd_en_q <= 1'b0;
                    if (start) begin
                        row_stride_q <= cfg_row_stride;
                        ch_stride_q  <= cfg_ch_stride;
                        len_q        <= cfg_length;
                        hgt_q        <= cfg_height;
                        dep_q        <= cfg_depth;
                        zf_q         <= cfg_zero_fill;
                        x_q          <= '0;
                        r_q          <= '0;
                        c_q          <= '0;
                        addr_q       <= cfg_glb_base;
                        row_q        <= cfg_glb_base;
                        ch_q         <= cfg_glb_base;
                        wr_ptr_q     <= cfg_lb_base;
                        if (cfg_length == '0 || cfg_height == '0 || cfg_depth == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            busy_q  <= 1'b1;
                            acc_v_q <= 1'b1;
                            rd_en_q <= !cfg_zero_fill;
                            if (!cfg_zero_fill) rd_addr_q <= cfg_glb_base;
                        end
                    end
                end
                ISSUE: begin
                    if (last_acc) begin
                        acc_v_q <= 1'b0;
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        x_q     <= x_d;
                        r_q     <= r_d;
                        c_q     <= c_d;
                        addr_q  <= addr_d;
                        row_q   <= row_d;
                        ch_q    <= ch_d;
                        acc_v_q <= 1'b1;
                        rd_en_q <= !zf_q;
                        if (!zf_q) rd_addr_q <= addr_d;
                    end
                end
                DRAIN: begin
                    if (!pipe_pending) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = vpipe_q[RD_LAT-1];
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_glb_2_lb_dma.sv
// Randomized bench for glb_2_lb_dma: two instances (RD_LAT=1 and RD_LAT=3) share
// stimulus; a nested-loop tile model predicts every output cycle by cycle.
module tb_glb_2_lb_dma;
    localparam int DW   = 128;
    localparam int GAW  = 15;
    localparam int LAW  = 10;
    localparam int DIMW = 6;
    localparam int SW   = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            rst, start;
    logic [GAW-1:0]  cfg_glb_base;
    logic [LAW-1:0]  cfg_lb_base;
    logic [SW-1:0]   cfg_row_stride;
    logic [GAW-1:0]  cfg_ch_stride;
    logic [DIMW-1:0] cfg_length, cfg_height, cfg_depth;
    logic            cfg_zero_fill;
    logic [31:0]     salt;

    logic           busy_a, done_a, rd_en_a, wr_en_a;
    logic [GAW-1:0] rd_addr_a;
    logic [DW-1:0]  rd_data_a, wr_data_a;
    logic [LAW-1:0] wr_addr_a;
    logic           busy_b, done_b, rd_en_b, wr_en_b;
    logic [GAW-1:0] rd_addr_b, ad_b1, ad_b2;
    logic [DW-1:0]  rd_data_b, wr_data_b;
    logic [LAW-1:0] wr_addr_b;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_addr[$];

    function automatic logic [DW-1:0] mem_f(input logic [GAW-1:0] a, input logic [31:0] s);
        return DW'(a) ^ {4{s}};
    endfunction

    // Global buffer models: data must be present on the RD_LAT-th edge after rd_en rises.
    assign rd_data_a = mem_f(rd_addr_a, salt);
    always @(posedge clock) begin
        ad_b1 <= rd_addr_b;
        ad_b2 <= ad_b1;
    end
    assign rd_data_b = mem_f(ad_b2, salt);

    glb_2_lb_dma #(.DATA_W(DW), .GLB_AW(GAW), .LB_AW(LAW), .DIM_W(DIMW),
                   .STRIDE_W(SW), .RD_LAT(1)) u_dut_l1 (
        .clock(clock), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .cfg_glb_base(cfg_glb_base), .cfg_lb_base(cfg_lb_base),
        .cfg_row_stride(cfg_row_stride), .cfg_ch_stride(cfg_ch_stride),
        .cfg_length(cfg_length), .cfg_height(cfg_height), .cfg_depth(cfg_depth),
        .cfg_zero_fill(cfg_zero_fill), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a));

    glb_2_lb_dma #(.DATA_W(DW), .GLB_AW(GAW), .LB_AW(LAW), .DIM_W(DIMW),
                   .STRIDE_W(SW), .RD_LAT(3)) u_dut_l3 (
        .clock(clock), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .cfg_glb_base(cfg_glb_base), .cfg_lb_base(cfg_lb_base),
        .cfg_row_stride(cfg_row_stride), .cfg_ch_stride(cfg_ch_stride),
        .cfg_length(cfg_length), .cfg_height(cfg_height), .cfg_depth(cfg_depth),
        .cfg_zero_fill(cfg_zero_fill), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b));

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic check_dut(input string who, input int lat, input int t, input int n,
                             input bit zf, input int lb,
                             input logic rd_en, input logic [GAW-1:0] rd_addr,
                             input logic wr_en, input logic [LAW-1:0] wr_addr,
                             input logic [DW-1:0] wr_data, input logic busy, input logic done);
        bit e_rd, e_wr, e_busy, e_done;
        int idx;
        e_rd   = !zf && t >= 1 && t <= n;
        e_wr   = n > 0 && t >= lat + 1 && t <= n + lat;
        e_busy = n > 0 && t >= 1 && t <= n + lat;
        e_done = (n == 0) ? (t == 1) : (t == n + lat + 1);
        chk($sformatf("%s t=%0d rd_en", who, t), DW'(rd_en), DW'(e_rd));
        if (e_rd)
            chk($sformatf("%s t=%0d rd_addr", who, t), DW'(rd_addr), DW'(exp_addr[t-1]));
        chk($sformatf("%s t=%0d wr_en", who, t), DW'(wr_en), DW'(e_wr));
        if (e_wr) begin
            idx = t - lat - 1;
            chk($sformatf("%s t=%0d wr_addr", who, t), DW'(wr_addr), DW'((lb + idx) % 1024));
            chk($sformatf("%s t=%0d wr_data", who, t), wr_data,
                zf ? '0 : mem_f(GAW'(exp_addr[idx]), salt));
        end else begin
            chk($sformatf("%s t=%0d wr_data_idle", who, t), wr_data, '0);
        end
        chk($sformatf("%s t=%0d busy", who, t), DW'(busy), DW'(e_busy));
        chk($sformatf("%s t=%0d done", who, t), DW'(done), DW'(e_done));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " a.rd_en"},   DW'(rd_en_a),   '0);
        chk({tag, " a.rd_addr"}, DW'(rd_addr_a), '0);
        chk({tag, " a.wr_en"},   DW'(wr_en_a),   '0);
        chk({tag, " a.wr_addr"}, DW'(wr_addr_a), '0);
        chk({tag, " a.wr_data"}, wr_data_a,      '0);
        chk({tag, " a.busy"},    DW'(busy_a),    '0);
        chk({tag, " a.done"},    DW'(done_a),    '0);
        chk({tag, " b.rd_en"},   DW'(rd_en_b),   '0);
        chk({tag, " b.rd_addr"}, DW'(rd_addr_b), '0);
        chk({tag, " b.wr_en"},   DW'(wr_en_b),   '0);
        chk({tag, " b.wr_addr"}, DW'(wr_addr_b), '0);
        chk({tag, " b.wr_data"}, wr_data_b,      '0);
        chk({tag, " b.busy"},    DW'(busy_b),    '0);
        chk({tag, " b.done"},    DW'(done_b),    '0);
    endtask

    task automatic scramble_cfg();
        cfg_glb_base   = GAW'($urandom);
        cfg_lb_base    = LAW'($urandom);
        cfg_row_stride = SW'($urandom);
        cfg_ch_stride  = GAW'($urandom);
        cfg_length     = DIMW'($urandom);
        cfg_height     = DIMW'($urandom);
        cfg_depth      = DIMW'($urandom);
        cfg_zero_fill  = 1'($urandom);
    endtask

    task automatic load_cfg(input int gb, input int lb, input int rs, input int cs,
                            input int len, input int hgt, input int dep, input bit zf);
        cfg_glb_base   = GAW'(gb);
        cfg_lb_base    = LAW'(lb);
        cfg_row_stride = SW'(rs);
        cfg_ch_stride  = GAW'(cs);
        cfg_length     = DIMW'(len);
        cfg_height     = DIMW'(hgt);
        cfg_depth      = DIMW'(dep);
        cfg_zero_fill  = zf;
    endtask

    // Called at a negedge with both instances idle; returns at a negedge, idle again.
    task automatic run(input int gb, input int lb, input int rs, input int cs,
                       input int len, input int hgt, input int dep, input bit zf,
                       input bit poke);
        int n;
        n = len * hgt * dep;
        exp_addr.delete();
        for (int c = 0; c < dep; c++)
            for (int r = 0; r < hgt; r++)
                for (int x = 0; x < len; x++)
                    exp_addr.push_back((gb + c * cs + r * rs + x) & 32'h7fff);
        load_cfg(gb, lb, rs, cs, len, hgt, dep, zf);
        start = 1'b1;
        for (int t = 1; t <= n + 6; t++) begin
            @(negedge clock);
            check_dut("L1", 1, t, n, zf, lb, rd_en_a, rd_addr_a, wr_en_a, wr_addr_a,
                      wr_data_a, busy_a, done_a);
            check_dut("L3", 3, t, n, zf, lb, rd_en_b, rd_addr_b, wr_en_b, wr_addr_b,
                      wr_data_b, busy_b, done_b);
            start = 1'b0;
            if (t == 1) scramble_cfg();
            if (poke && n >= 1 && t == 3) start = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        salt = '0;
        load_cfg(0, 0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clock);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clock);

        run(0, 0, 3, 0, 3, 3, 1, 1'b0, 1'b0);
        run(5, 20, 8, 100, 3, 3, 2, 1'b0, 1'b0);
        salt = 32'hDEAD_BEEF;
        run(0, 50, 1, 1, 4, 2, 1, 1'b1, 1'b0);
        run(32766, 1022, 0, 0, 4, 1, 1, 1'b0, 1'b0);
        run(7, 3, 2, 9, 3, 0, 2, 1'b0, 1'b0);
        run(10, 7, 5, 40, 3, 2, 2, 1'b0, 1'b1);

        // Reset in the middle of a 3x3x1 tile, then rerun the same tile.
        load_cfg(100, 30, 4, 0, 3, 3, 1, 1'b0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        rst = 1'b1;
        #1;
        check_zero("midreset");
        repeat (2) begin
            @(negedge clock);
            check_zero("inreset");
        end
        rst = 1'b0;
        @(negedge clock);
        run(100, 30, 4, 0, 3, 3, 1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            salt = $urandom;
            run(int'($urandom_range(0, 32767)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 32767)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/glb_2_lb_dma.md
# glb_2_lb_dma

Parametrised successor to the global-buffer-to-local-buffer tile mover. It copies a 3-D tile (length × height × depth words) out of the global buffer, using a programmable row stride and channel stride, into a contiguous region of a local buffer. It tolerates a configurable global-buffer read latency and supports a zero-fill mode for clearing local-buffer regions. It sits between the global buffer read port and one local buffer write port, driven by the tile controller through a start/busy/done handshake.

## Interface
- DATA_W, 128, word width of global and local buffers
- GLB_AW, 15, global buffer address width
- LB_AW, 10, local buffer address width
- DIM_W, 6, width of length/height/depth fields
- STRIDE_W, 8, width of row stride field
- RD_LAT, 1, global buffer read latency in cycles (≥1)

- clock  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- cfg_glb_base  in  GLB_AW  first global address
- cfg_lb_base  in  LB_AW  first local address
- cfg_row_stride  in  STRIDE_W  global address step between rows
- cfg_ch_stride  in  GLB_AW  global address step between channels
- cfg_length  in  DIM_W  words per row
- cfg_height  in  DIM_W  rows per channel
- cfg_depth  in  DIM_W  channels
- cfg_zero_fill  in  1  1 = write zeros, issue no reads
- rd_en  out  1  global buffer read strobe
- rd_addr  out  GLB_AW  global read address
- rd_data  in  DATA_W  read data, valid RD_LAT cycles after rd_en
- wr_en  out  1  local buffer write strobe
- wr_addr  out  LB_AW  local write address
- wr_data  out  DATA_W  local write data

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when start=1, all cfg_* are latched into internal registers. cfg_* are don't-care afterwards.
  - If any of length, height or depth is 0, go to DONE: no reads and no writes.
  - Otherwise go to ISSUE, with counters x=r=c=0 and local index k=0.
- ISSUE: one access per cycle.
  - Global address = glb_base + c·ch_stride + r·row_stride + x, computed modulo 2^GLB_AW.
  - x is the innermost counter, then r, then c.
  - rd_en=1 unless zero_fill=1. When zero_fill=1, rd_en stays 0 and rd_addr holds its last value.
  - After the access with x=L-1, r=H-1, c=D-1, go to DRAIN.
- Write path: a RD_LAT-deep valid pipeline tracks every issued access, including zero-fill accesses.
  - When the pipeline is valid: wr_en=1, wr_addr = lb_base + k (modulo 2^LB_AW, wraps silently), and k increments.
  - wr_data = rd_data, or 0 when zero_fill=1.
  - wr_data is 0 whenever wr_en=0.
- DRAIN: issue nothing. Stay until the last write has been emitted, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- start is ignored while busy=1 or during DONE.
- rst at any time returns the block to IDLE immediately. In-flight writes are dropped and no done is produced.

## Timing
- Reset values: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- Let start be sampled at edge T and let N = L·H·D.
  - First rd_en is in cycle T+1; the last is in cycle T+N. Reads are back-to-back with no bubbles.
  - Write for access i (1-based) is in cycle T+i+RD_LAT.
  - Last wr_en is in cycle T+N+RD_LAT.
  - done is in cycle T+N+RD_LAT+1.
  - busy=1 from T+1 through T+N+RD_LAT.
- Zero-dimension request: done in cycle T+1, and busy never rises.
- Earliest accepted re-start is the edge on which done is low again, i.e. cycle T+N+RD_LAT+2.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- RD_LAT=1; base=0, row_stride=3, ch_stride=0, L=H=D=3 wait, D=1; rd_data=address → rd_addr 0..8 in 9 consecutive cycles; wr_addr 0..8 with wr_data 0..8; done at T+11.
- RD_LAT=3; base=5, row_stride=8, L=H=3, D=2, ch_stride=100, lb_base=20 → rd_addr 5,6,7,13,14,15,21,22,23,105,106,107,113,114,115,121,122,123; wr_addr 20..37 with matching data; done at T+22.
- zero_fill=1, L=4, H=2, D=1, lb_base=50 → rd_en never asserted; wr_addr 50..57 with wr_data=0; done at T+10 (RD_LAT=1).
- Wrap: lb_base=1022, L=4, H=D=1, glb_base=32766 → rd_addr 32766,32767,0,1; wr_addr 1022,1023,0,1.
- Height=0 → done at T+1, no rd_en/wr_en; start pulsed mid-transfer → ignored, access sequence and done timing unchanged.
- rst asserted during ISSUE of a 3×3×1 tile → all outputs 0 immediately, no done; the next start runs the full tile correctly.
